// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode encodings and FSM states.
// Opcodes match what the shared ALU decodes.
package alu_rr_arbiter_pkg;

  localparam int ALU_N   = 32;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_NOT = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic gnt,
  output logic any
);

  assign any = v0 | v1;
  assign gnt = (v0 & v1) ? ptr : v1;

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin
// arbitration and a single registered response tagged with the owning requester id.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_y,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_data,
  input  logic           rsp_ready
);

  logic [1:0] state;
  logic       ptr;
  logic       gnt;
  logic       any;
  logic       accept;

  rr_arb2 u_arb (
    .v0  (req0_valid),
    .v1  (req1_valid),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  // NOTE: ready is combinational from state, so it must also be masked by rst;
  // otherwise a requester could see a handshake during a reset cycle that the FSM ignores.
  assign accept = !rst && (state == S_IDLE) && any;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = ~gnt;
      req1_ready = gnt;
    end
  end

  // The ALU operand outputs double as the operand registers: loaded at accept,
  // they are stable through EXEC and then simply hold their last value.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            alu_op <= gnt ? req1_op : req0_op;
            alu_a  <= gnt ? req1_a  : req0_a;
            alu_b  <= gnt ? req1_b  : req0_b;
            rsp_id <= gnt;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_y;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          // The pointer only moves once a response is actually consumed.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ~rsp_id;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: the bench models the shared ALU, pushes the
// expected response of every accepted request to a scoreboard and pops it on each response.
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  localparam int N   = 32;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [N-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [N-1:0]   req1_a, req1_b;
  logic [OPW-1:0] alu_op;
  logic [N-1:0]   alu_a, alu_b, alu_y;
  logic           rsp_valid, rsp_id;
  logic [N-1:0]   rsp_data;
  logic           rsp_ready;

  alu_rr_arbiter #(.N(N), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_ref(logic [OPW-1:0] op, logic [N-1:0] a, logic [N-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOT: return ~a;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return '0;
    endcase
  endfunction

  // The shared combinational ALU sitting behind the arbiter.
  always_comb alu_y = alu_ref(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic         id;
    logic [N-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t done_q[$];
  int   checks = 0;
  int   errors = 0;
  logic hs0, hs1;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: observe handshakes just before the edge, retire accepted
  // requests just after it, and return on the falling edge with outputs settled.
  task automatic tick();
    rsp_t e;
    #1;
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (!rst) begin
      check("ready_onehot", N'(req0_ready & req1_ready), '0);
      if (req0_valid && req0_ready) begin
        hs0 = 1'b1;
        sb.push_back('{1'b0, alu_ref(req0_op, req0_a, req0_b)});
      end
      if (req1_valid && req1_ready) begin
        hs1 = 1'b1;
        sb.push_back('{1'b1, alu_ref(req1_op, req1_a, req1_b)});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", N'(rsp_valid), '0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", N'(rsp_id), N'(e.id));
          check("rsp_data", rsp_data, e.data);
        end
        done_q.push_back('{rsp_id, rsp_data});
      end
    end
    @(posedge clk);
    #1;
    if (hs0) req0_valid = 1'b0;
    if (hs1) req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic set0(input logic [OPW-1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [OPW-1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (done_q.size() < n) check("wait_done_timeout", N'(done_q.size()), N'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, n1, k;
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset held with both requesters pending.
    set0(ALU_ADD, 32'd1, 32'd2);
    set1(ALU_OR, 32'd3, 32'd4);
    tick();
    tick();
    check("rst_req0_ready", N'(req0_ready), '0);
    check("rst_req1_ready", N'(req1_ready), '0);
    check("rst_rsp_valid", N'(rsp_valid), '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_id", N'(rsp_id), '0);
    check("rst_alu_a", alu_a, '0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single op with latency check: accept at T, EXEC at T+1, response at T+2.
    set0(ALU_ADD, 32'd5, 32'd7);
    tick();
    check("t2_accept", N'(hs0), 32'd1);
    check("t2_exec_no_rsp", N'(rsp_valid), '0);
    tick();
    check("t2_rsp_valid", N'(rsp_valid), 32'd1);
    check("t2_rsp_id", N'(rsp_id), '0);
    check("t2_rsp_data", rsp_data, 32'd12);
    wait_done(1, 5);

    // Contention from reset: both requesters re-issue immediately, grants must alternate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = done_q.size();
    n0 = 0;
    n1 = 0;
    set0(ALU_SUB, 32'd10, 32'd3);
    set1(ALU_AND, 32'hFF, 32'h0F);
    k = 0;
    while (done_q.size() < base + 6 && k < 60) begin
      tick();
      if (hs0) begin n0++; if (n0 < 3) set0(ALU_SUB, 32'd10, 32'd3); end
      if (hs1) begin n1++; if (n1 < 3) set1(ALU_AND, 32'hFF, 32'h0F); end
      k++;
    end
    if (done_q.size() < base + 6) begin
      check("t3_timeout", N'(done_q.size()), N'(base + 6));
    end else begin
      for (int i = 0; i < 6; i++) check("t3_order", N'(done_q[base+i].id), N'(i % 2));
      check("t3_first_data", done_q[base].data, 32'd7);
      check("t3_second_data", done_q[base+1].data, 32'h0F);
    end

    // Backpressure: response held for 5 cycles while another request waits.
    rsp_ready = 1'b0;
    set0(ALU_ADD, 32'hFFFF_FFFF, 32'd2);
    tick();
    check("t4_accept", N'(hs0), 32'd1);
    tick();
    tick();
    set1(ALU_OR, 32'hA0, 32'h05);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", N'(rsp_valid), 32'd1);
      check("t4_hold_id", N'(rsp_id), '0);
      check("t4_hold_data", rsp_data, 32'd1);
      check("t4_hold_ready0", N'(req0_ready), '0);
      check("t4_hold_ready1", N'(req1_ready), '0);
      tick();
    end
    base = done_q.size();
    rsp_ready = 1'b1;
    tick();
    check("t4_released", N'(done_q.size()), N'(base + 1));
    check("t4_idle_ready1", N'(req1_ready), 32'd1);
    tick();
    check("t4_accept1", N'(hs1), 32'd1);
    wait_done(base + 2, 6);

    // Mid-op reset after forcing ptr to 1: no stale response, ptr back to 0.
    set0(ALU_OR, 32'd0, 32'h55);
    wait_done(done_q.size() + 1, 8);
    base = done_q.size();
    set1(ALU_ADD, 32'd100, 32'd200);
    tick();
    check("t5_accept", N'(hs1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("t5_rsp_valid", N'(rsp_valid), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_stale", N'(rsp_valid), '0);
    end
    check("t5_no_rsp", N'(done_q.size()), N'(base));
    set0(ALU_AND, 32'hF0F0, 32'hFF00);
    set1(ALU_SUB, 32'd1, 32'd2);
    wait_done(base + 2, 12);
    if (done_q.size() >= base + 2) begin
      check("t5_first_id", N'(done_q[base].id), '0);
      check("t5_first_data", done_q[base].data, 32'hF000);
      check("t5_second_id", N'(done_q[base+1].id), 32'd1);
      check("t5_second_data", done_q[base+1].data, 32'hFFFF_FFFF);
    end

    // Lone requester wins even though ptr favours the other side.
    set0(ALU_ADD, 32'd1, 32'd1);
    wait_done(done_q.size() + 1, 8);
    base = done_q.size();
    set0(ALU_NOT, 32'd0, 32'd0);
    tick();
    check("t6_lone_accept", N'(hs0), 32'd1);
    wait_done(base + 1, 6);
    if (done_q.size() >= base + 1) begin
      check("t6_id", N'(done_q[base].id), '0);
      check("t6_data", done_q[base].data, 32'hFFFF_FFFF);
    end
    check("sb_empty", N'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
